// File: rtl/mips_sc_exec_ctrl.sv
// ---------------------------------------------------------------------------
// mips_sc_exec_ctrl
//
// Single-cycle execution and control core for a MIPS subset. Decodes the
// instruction word coming from the ROM, produces register-file and
// data-memory control, computes the ALU result and owns the word-addressed
// program counter, a sticky halt flag and a cycle counter.
//
// Ports
//   clk            rising-edge clock
//   clr            synchronous active-high reset
//   ins            current instruction (combinational from ROM at pc)
//   rs_data        register-file value of ins[25:21]
//   rt_data        register-file value of ins[20:16]
//   v0_data        current value of register 2 ($v0), used by syscall
//   pc             current instruction word address (register)
//   cycle_count    edges counted since reset while not halted (register)
//   halted         sticky halt flag (register)
//   alu_result     ALU output, also the data-memory byte address
//   alu_zero       alu_result == 0
//   reg_write_num  destination register number
//   reg_write_en   register write strobe
//   reg_write_sel  writeback source: 0 ALU, 1 data memory, 2 pc+1
//   pc_plus1       pc + 1, the link value
//   mem_cs         data-memory select
//   mem_rd         1 = read, 0 = write, meaningful while mem_cs is high
// ---------------------------------------------------------------------------
module mips_sc_exec_ctrl (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ins,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] v0_data,
  output logic [31:0] pc,
  output logic [31:0] cycle_count,
  output logic        halted,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  output logic [4:0]  reg_write_num,
  output logic        reg_write_en,
  output logic [1:0]  reg_write_sel,
  output logic [31:0] pc_plus1,
  output logic        mem_cs,
  output logic        mem_rd
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [31:0] HALT_SERVICE = 32'd10;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_t;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic [4:0]  rd_field;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] jump_target;

  // Decoded controls
  alu_op_t     alu_op;
  logic        use_imm;
  logic        use_zext;
  logic        dec_write;
  logic [4:0]  dec_write_num;
  logic [1:0]  dec_write_sel;
  logic        dec_mem;
  logic        dec_mem_rd;
  logic        is_jr;
  logic        is_jump;
  logic        is_beq;
  logic        is_bne;
  logic        is_syscall;

  // Datapath / sequencing
  logic [31:0] operand_b;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic        halting;
  logic [31:0] pc_next;
  state_t      state;
  state_t      state_next;

  assign opcode      = ins[31:26];
  assign rt_field    = ins[20:16];
  assign rd_field    = ins[15:11];
  assign shamt       = ins[10:6];
  assign funct       = ins[5:0];
  assign imm         = ins[15:0];
  assign imm_sext    = {{16{imm[15]}}, imm};
  assign imm_zext    = {16'h0000, imm};
  assign jump_target = {6'b000000, ins[25:0]};

  // Instruction decode. Everything defaults to a NOP so any encoding not
  // listed below writes nothing, touches no memory and falls through to
  // pc+1. add/sub share the wrapping adder with addu/subu since overflow
  // never traps in this core.
  always_comb begin
    alu_op        = ALU_ADD;
    use_imm       = 1'b0;
    use_zext      = 1'b0;
    dec_write     = 1'b0;
    dec_write_num = rt_field;
    dec_write_sel = 2'd0;
    dec_mem       = 1'b0;
    dec_mem_rd    = 1'b0;
    is_jr         = 1'b0;
    is_jump       = 1'b0;
    is_beq        = 1'b0;
    is_bne        = 1'b0;
    is_syscall    = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        dec_write_num = rd_field;
        case (funct)
          FN_ADD, FN_ADDU: begin alu_op = ALU_ADD;  dec_write = 1'b1; end
          FN_SUB, FN_SUBU: begin alu_op = ALU_SUB;  dec_write = 1'b1; end
          FN_AND:          begin alu_op = ALU_AND;  dec_write = 1'b1; end
          FN_OR:           begin alu_op = ALU_OR;   dec_write = 1'b1; end
          FN_XOR:          begin alu_op = ALU_XOR;  dec_write = 1'b1; end
          FN_NOR:          begin alu_op = ALU_NOR;  dec_write = 1'b1; end
          FN_SLT:          begin alu_op = ALU_SLT;  dec_write = 1'b1; end
          FN_SLTU:         begin alu_op = ALU_SLTU; dec_write = 1'b1; end
          FN_SLL:          begin alu_op = ALU_SLL;  dec_write = 1'b1; end
          FN_SRL:          begin alu_op = ALU_SRL;  dec_write = 1'b1; end
          FN_SRA:          begin alu_op = ALU_SRA;  dec_write = 1'b1; end
          FN_JR:           is_jr      = 1'b1;
          FN_SYSCALL:      is_syscall = 1'b1;
          default:         ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        alu_op = ALU_ADD;  use_imm = 1'b1; dec_write = 1'b1;
      end
      OP_SLTI: begin
        alu_op = ALU_SLT;  use_imm = 1'b1; dec_write = 1'b1;
      end
      OP_SLTIU: begin
        alu_op = ALU_SLTU; use_imm = 1'b1; dec_write = 1'b1;
      end
      OP_ANDI: begin
        alu_op = ALU_AND;  use_imm = 1'b1; use_zext = 1'b1; dec_write = 1'b1;
      end
      OP_ORI: begin
        alu_op = ALU_OR;   use_imm = 1'b1; use_zext = 1'b1; dec_write = 1'b1;
      end
      OP_XORI: begin
        alu_op = ALU_XOR;  use_imm = 1'b1; use_zext = 1'b1; dec_write = 1'b1;
      end
      OP_LUI: begin
        alu_op = ALU_LUI;  dec_write = 1'b1;
      end
      OP_LW: begin
        alu_op        = ALU_ADD;
        use_imm       = 1'b1;
        dec_write     = 1'b1;
        dec_write_sel = 2'd1;
        dec_mem       = 1'b1;
        dec_mem_rd    = 1'b1;
      end
      OP_SW: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        dec_mem = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        is_beq = 1'b1;
      end
      OP_BNE: begin
        alu_op = ALU_SUB;
        is_bne = 1'b1;
      end
      OP_J: begin
        is_jump = 1'b1;
      end
      OP_JAL: begin
        is_jump       = 1'b1;
        dec_write     = 1'b1;
        dec_write_num = 5'd31;
        dec_write_sel = 2'd2;
      end
      default: ;
    endcase
  end

  // ALU. The second operand is rt_data for R-type and branches, otherwise
  // the immediate with the extension the opcode asks for. Shifts always
  // work on rt_data by shamt.
  always_comb begin
    if (use_imm) begin
      operand_b = use_zext ? imm_zext : imm_sext;
    end else begin
      operand_b = rt_data;
    end

    case (alu_op)
      ALU_ADD:  alu_result = rs_data + operand_b;
      ALU_SUB:  alu_result = rs_data - operand_b;
      ALU_AND:  alu_result = rs_data & operand_b;
      ALU_OR:   alu_result = rs_data | operand_b;
      ALU_XOR:  alu_result = rs_data ^ operand_b;
      ALU_NOR:  alu_result = ~(rs_data | operand_b);
      ALU_SLT:  alu_result = {31'd0, $signed(rs_data) < $signed(operand_b)};
      ALU_SLTU: alu_result = {31'd0, rs_data < operand_b};
      ALU_SLL:  alu_result = rt_data << shamt;
      ALU_SRL:  alu_result = rt_data >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(rt_data) >>> shamt);
      ALU_LUI:  alu_result = {imm, 16'h0000};
      default:  alu_result = 32'd0;
    endcase
  end

  assign alu_zero = (alu_result == 32'd0);

  // Next-PC selection. A halting syscall, like an already halted core,
  // keeps the PC parked on the syscall itself so a debugger sees where the
  // program stopped. Branch offsets are relative to pc+1.
  always_comb begin
    pc_plus1      = pc + 32'd1;
    branch_target = pc_plus1 + imm_sext;
    branch_taken  = (is_beq && alu_zero) || (is_bne && !alu_zero);
    halting       = is_syscall && (v0_data == HALT_SERVICE) && (state == ST_RUN);

    if (halted || halting) begin
      pc_next = pc;
    end else if (is_jr) begin
      pc_next = rs_data;
    end else if (is_jump) begin
      pc_next = jump_target;
    end else if (branch_taken) begin
      pc_next = branch_target;
    end else begin
      pc_next = pc_plus1;
    end
  end

  // Run/halt state register. Reset wins over everything, including an
  // already halted core, so clr restarts a stopped program.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Run/halt next state: the only way out of ST_HALTED is reset.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (halting) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  // Run/halt outputs. While halted the core must not disturb the register
  // file or memory, so the strobes are squashed here; the register number,
  // source select and read/write direction pass through untouched.
  always_comb begin
    halted        = (state == ST_HALTED);
    reg_write_en  = dec_write && !halted;
    mem_cs        = dec_mem && !halted;
    reg_write_num = dec_write_num;
    reg_write_sel = dec_write_sel;
    mem_rd        = dec_mem_rd;
  end

  // PC and cycle counter. Both freeze once halted; the counter still counts
  // the edge on which the halting syscall itself executes because the state
  // only turns to halted after that edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc          <= 32'd0;
      cycle_count <= 32'd0;
    end else if (!halted) begin
      pc          <= pc_next;
      cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips_sc_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_sc_exec_ctrl
//
// Self-checking bench for mips_sc_exec_ctrl. Each step drives one
// instruction with its operand values, compares the combinational outputs
// against an instruction-level reference model, clocks once and compares
// pc / cycle_count / halted against the model's architectural state.
// ---------------------------------------------------------------------------
module tb_mips_sc_exec_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ins;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] v0_data;
  logic [31:0] pc;
  logic [31:0] cycle_count;
  logic        halted;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [4:0]  reg_write_num;
  logic        reg_write_en;
  logic [1:0]  reg_write_sel;
  logic [31:0] pc_plus1;
  logic        mem_cs;
  logic        mem_rd;

  int compared   = 0;
  int mismatched = 0;

  // Architectural state tracked by the model
  logic [31:0] m_pc;
  logic [31:0] m_cycle;
  logic        m_halted;

  typedef struct {
    logic [31:0] alu;
    logic        alu_ok;
    logic        wen;
    logic [4:0]  wnum;
    logic [1:0]  wsel;
    logic        cs;
    logic        rd;
    logic [31:0] next_pc;
    logic [31:0] link;
    logic        halting;
  } exp_t;

  mips_sc_exec_ctrl dut (
    .clk           (clk),
    .clr           (clr),
    .ins           (ins),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .v0_data       (v0_data),
    .pc            (pc),
    .cycle_count   (cycle_count),
    .halted        (halted),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .reg_write_num (reg_write_num),
    .reg_write_en  (reg_write_en),
    .reg_write_sel (reg_write_sel),
    .pc_plus1      (pc_plus1),
    .mem_cs        (mem_cs),
    .mem_rd        (mem_rd)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case the run ever wedges
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction builders
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // Instruction-level reference: what one instruction does to the
  // architecturally visible outputs, written case by case from the ISA.
  function automatic exp_t refModel(input logic [31:0] i, input logic [31:0] r,
                                    input logic [31:0] t, input logic [31:0] v,
                                    input logic [31:0] p, input logic h);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [15:0] im;
    logic [31:0] se;
    logic [31:0] ze;
    op = i[31:26];
    fn = i[5:0];
    sh = i[10:6];
    im = i[15:0];
    se = {{16{im[15]}}, im};
    ze = {16'h0, im};
    e.alu = 32'd0;  e.alu_ok = 1'b0;
    e.wen = 1'b0;   e.wnum = 5'd0;  e.wsel = 2'd0;
    e.cs = 1'b0;    e.rd = 1'b0;
    e.link = p + 32'd1;
    e.next_pc = p + 32'd1;
    e.halting = 1'b0;

    if (op == 6'h00) begin
      e.alu_ok = 1'b1;
      e.wen = 1'b1;
      e.wnum = i[15:11];
      case (fn)
        6'h20, 6'h21: e.alu = r + t;
        6'h22, 6'h23: e.alu = r - t;
        6'h24: e.alu = r & t;
        6'h25: e.alu = r | t;
        6'h26: e.alu = r ^ t;
        6'h27: e.alu = ~(r | t);
        6'h2A: e.alu = ($signed(r) < $signed(t)) ? 32'd1 : 32'd0;
        6'h2B: e.alu = (r < t) ? 32'd1 : 32'd0;
        6'h00: e.alu = t << sh;
        6'h02: e.alu = t >> sh;
        6'h03: e.alu = $unsigned($signed(t) >>> sh);
        default: begin
          e.alu_ok = 1'b0;
          e.wen = 1'b0;
          if (fn == 6'h08) e.next_pc = r;
          if (fn == 6'h0C && v == 32'd10) e.halting = 1'b1;
        end
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin e.alu = r + se; e.alu_ok = 1'b1; e.wen = 1'b1; end
        6'h0A: begin e.alu = ($signed(r) < $signed(se)) ? 32'd1 : 32'd0; e.alu_ok = 1'b1; e.wen = 1'b1; end
        6'h0B: begin e.alu = (r < se) ? 32'd1 : 32'd0; e.alu_ok = 1'b1; e.wen = 1'b1; end
        6'h0C: begin e.alu = r & ze; e.alu_ok = 1'b1; e.wen = 1'b1; end
        6'h0D: begin e.alu = r | ze; e.alu_ok = 1'b1; e.wen = 1'b1; end
        6'h0E: begin e.alu = r ^ ze; e.alu_ok = 1'b1; e.wen = 1'b1; end
        6'h0F: begin e.alu = {im, 16'h0}; e.alu_ok = 1'b1; e.wen = 1'b1; end
        6'h23: begin
          e.alu = r + se; e.alu_ok = 1'b1;
          e.wen = 1'b1; e.wsel = 2'd1; e.cs = 1'b1; e.rd = 1'b1;
        end
        6'h2B: begin e.alu = r + se; e.alu_ok = 1'b1; e.cs = 1'b1; e.rd = 1'b0; end
        6'h04: begin
          e.alu = r - t; e.alu_ok = 1'b1;
          if (r == t) e.next_pc = p + 32'd1 + se;
        end
        6'h05: begin
          e.alu = r - t; e.alu_ok = 1'b1;
          if (r != t) e.next_pc = p + 32'd1 + se;
        end
        6'h02: e.next_pc = {6'b0, i[25:0]};
        6'h03: begin
          e.next_pc = {6'b0, i[25:0]};
          e.wen = 1'b1; e.wsel = 2'd2;
        end
        default: ;
      endcase
      if (op != 6'h03) e.wnum = i[20:16];
      else             e.wnum = 5'd31;
    end

    if (h) begin
      e.wen = 1'b0;
      e.cs = 1'b0;
      e.halting = 1'b0;
      e.next_pc = p;
    end else if (e.halting) begin
      e.next_pc = p;
    end
    return e;
  endfunction

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (model pc %h)", tag, got, exp, m_pc);
    end
  endtask

  // One instruction step: drive, check decode, clock, check state
  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] r,
                               input logic [31:0] t, input logic [31:0] v,
                               input logic c);
    exp_t e;
    ins = i; rs_data = r; rt_data = t; v0_data = v; clr = c;
    #2;
    e = refModel(i, r, t, v, m_pc, m_halted);
    checkOutput("pc_plus1", pc_plus1, e.link);
    checkOutput("reg_write_en", 32'(reg_write_en), 32'(e.wen));
    checkOutput("mem_cs", 32'(mem_cs), 32'(e.cs));
    if (e.wen) begin
      checkOutput("reg_write_num", 32'(reg_write_num), 32'(e.wnum));
      checkOutput("reg_write_sel", 32'(reg_write_sel), 32'(e.wsel));
    end
    if (e.cs) checkOutput("mem_rd", 32'(mem_rd), 32'(e.rd));
    if (e.alu_ok) begin
      checkOutput("alu_result", alu_result, e.alu);
      checkOutput("alu_zero", 32'(alu_zero), (e.alu == 32'd0) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    if (c) begin
      m_pc = 32'd0; m_cycle = 32'd0; m_halted = 1'b0;
    end else if (!m_halted) begin
      m_pc = e.next_pc;
      m_cycle = m_cycle + 32'd1;
      m_halted = e.halting;
    end
    #1;
    checkOutput("pc", pc, m_pc);
    checkOutput("cycle_count", cycle_count, m_cycle);
    checkOutput("halted", 32'(halted), 32'(m_halted));
  endtask

  logic [5:0] rfn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h3F};
  logic [5:0] iop [16] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                           6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h01};

  initial begin
    logic [31:0] frozen;
    logic [31:0] ri;
    logic [31:0] rr;
    logic [31:0] rt;
    logic [31:0] rv;
    logic        rc;
    int          k;

    // Reset
    clr = 1'b1; ins = 32'd0; rs_data = 32'd0; rt_data = 32'd0; v0_data = 32'd0;
    @(posedge clk);
    #1;
    m_pc = 32'd0; m_cycle = 32'd0; m_halted = 1'b0;
    checkOutput("reset_pc", pc, 32'd0);
    checkOutput("reset_cycle", cycle_count, 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);

    // Straight-line addi $t0,$zero,5
    for (int n = 0; n < 3; n++) applyStimulus(32'h20080005, 32'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("addi_alu", alu_result, 32'd5);
    checkOutput("addi_wnum", 32'(reg_write_num), 32'd8);
    checkOutput("addi_pc", pc, 32'd3);
    checkOutput("addi_cycle", cycle_count, 32'd3);

    // beq taken backwards from pc 10, bne not taken
    applyStimulus(32'h0800000A, 32'd0, 32'd0, 32'd0, 1'b0);
    applyStimulus(itype(6'h04, 5'd8, 5'd9, 16'hFFFE), 32'd7, 32'd7, 32'd0, 1'b0);
    checkOutput("beq_pc", pc, 32'd9);
    applyStimulus(32'h0800000A, 32'd0, 32'd0, 32'd0, 1'b0);
    applyStimulus(itype(6'h05, 5'd8, 5'd9, 16'hFFFE), 32'd7, 32'd7, 32'd0, 1'b0);
    checkOutput("bne_pc", pc, 32'd11);

    // jal from pc 5, then jr
    applyStimulus(32'h08000005, 32'd0, 32'd0, 32'd0, 1'b0);
    applyStimulus(32'h0C000040, 32'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("jal_pc", pc, 32'h40);
    checkOutput("jal_wnum", 32'(reg_write_num), 32'd31);
    checkOutput("jal_wsel", 32'(reg_write_sel), 32'd2);
    applyStimulus(rtype(5'd9, 5'd0, 5'd0, 5'd0, 6'h08), 32'd6, 32'd0, 32'd0, 1'b0);
    checkOutput("jr_pc", pc, 32'd6);

    // Memory and lui
    applyStimulus(itype(6'h23, 5'd8, 5'd9, 16'hFFFC), 32'h100, 32'd0, 32'd0, 1'b0);
    checkOutput("lw_addr", alu_result, 32'hFC);
    checkOutput("lw_cs", 32'(mem_cs), 32'd1);
    checkOutput("lw_rd", 32'(mem_rd), 32'd1);
    checkOutput("lw_wsel", 32'(reg_write_sel), 32'd1);
    applyStimulus(itype(6'h2B, 5'd8, 5'd9, 16'hFFFC), 32'h100, 32'd0, 32'd0, 1'b0);
    checkOutput("sw_rd", 32'(mem_rd), 32'd0);
    checkOutput("sw_wen", 32'(reg_write_en), 32'd0);
    applyStimulus(itype(6'h0F, 5'd0, 5'd8, 16'h1234), 32'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("lui", alu_result, 32'h12340000);

    // ALU corners
    applyStimulus(rtype(5'd9, 5'd10, 5'd8, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    checkOutput("slt", alu_result, 32'd1);
    applyStimulus(rtype(5'd9, 5'd10, 5'd8, 5'd0, 6'h2B), 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    checkOutput("sltu", alu_result, 32'd0);
    applyStimulus(rtype(5'd0, 5'd10, 5'd8, 5'd4, 6'h03), 32'd0, 32'h80000000, 32'd0, 1'b0);
    checkOutput("sra", alu_result, 32'hF8000000);
    applyStimulus(rtype(5'd9, 5'd10, 5'd8, 5'd0, 6'h27), 32'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("nor", alu_result, 32'hFFFFFFFF);
    checkOutput("nor_zero", 32'(alu_zero), 32'd0);

    // Non-halting syscall, then halt at pc 7
    applyStimulus(32'h0000000C, 32'd0, 32'd0, 32'd1, 1'b0);
    applyStimulus(32'h08000007, 32'd0, 32'd0, 32'd0, 1'b0);
    applyStimulus(32'h0000000C, 32'd0, 32'd0, 32'd10, 1'b0);
    checkOutput("halt_flag", 32'(halted), 32'd1);
    checkOutput("halt_pc", pc, 32'd7);
    frozen = m_cycle;
    for (int n = 0; n < 5; n++) begin
      if (n % 2 == 0) applyStimulus(itype(6'h2B, 5'd8, 5'd9, 16'h0004), 32'h40, 32'd0, 32'd10, 1'b0);
      else            applyStimulus(32'h20080005, 32'd0, 32'd0, 32'd10, 1'b0);
    end
    checkOutput("halted_pc", pc, 32'd7);
    checkOutput("halted_cycle", cycle_count, frozen);
    applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    checkOutput("restart_pc", pc, 32'd0);
    checkOutput("restart_halted", 32'(halted), 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        ri = rtype(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   rfn[$urandom_range(0, 15)]);
      end else if (k < 8) begin
        ri = itype(iop[$urandom_range(0, 15)], 5'($urandom), 5'($urandom), 16'($urandom));
      end else begin
        ri = $urandom;
      end
      rr = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rr : $urandom;
      rv = ($urandom_range(0, 5) == 0) ? 32'd10 : 32'($urandom_range(0, 20));
      rc = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
      applyStimulus(ri, rr, rt, rv, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
